key_event_counter: RTL
======================

# key_event_counter

Input-side companion to the display counter path. It synchronizes and debounces one raw active-low push-button and turns each qualified press into a one-cycle event. Each event increments or decrements a wrap-around count whose value feeds the binary-to-7-segment wrapper, so a button-driven value can be shown instead of a clock-divided one. It runs on the board clock directly, with no divided clock.

## Interface
- DEBOUNCE_CYCLES, default 250000: consecutive stable synchronized samples needed to accept a level change (5 ms at 50 MHz); must be ≥ 2.
- WIDTH, default 8: count width.
- MAX_VALUE, default 255: highest count value; must be ≤ 2^WIDTH − 1.
- REPEAT_CYCLES, default 25000000: auto-repeat period in cycles; used only with the macro in Configuration.

Ports (clock and reset first):
- clk  in  1  board clock; all state changes on the rising edge.
- rst_n_a  in  1  asynchronous active-low reset.
- key_n  in  1  raw button, active-low, asynchronous to clk, bouncy.
- reverse  in  1  0 = count up, 1 = count down; sampled on the event edge only.
- clear  in  1  synchronous, active-high count clear.
- out_data  out  WIDTH  current count.
- press_pulse  out  1  one-cycle strobe per accepted event.
- wrap  out  1  one-cycle strobe when the count wraps.
- key_state  out  1  debounced level, 1 = pressed.

## Operation
- Synchronizer: two flops on key_n. Both reset to 1 (released), so reset never produces a spurious press. Its output is key_sync.
- FSM states and transitions, with debounce counter cnt:
  - IDLE: key_sync = 0 → PRESS_WAIT, cnt ← 1.
  - PRESS_WAIT:
    - key_sync = 1 → IDLE, cnt ← 0.
    - else if cnt = DEBOUNCE_CYCLES − 1 → PRESSED. The event fires and key_state ← 1.
    - else cnt ← cnt + 1.
  - PRESSED: key_sync = 1 → RELEASE_WAIT, cnt ← 1.
  - RELEASE_WAIT:
    - key_sync = 0 → PRESSED, cnt ← 0. No new event.
    - else if cnt = DEBOUNCE_CYCLES − 1 → IDLE, key_state ← 0.
    - else cnt ← cnt + 1.
- An event needs exactly DEBOUNCE_CYCLES consecutive low key_sync samples. Release never produces an event.
- On an event:
  - reverse = 0: out_data ← out_data + 1. At MAX_VALUE it goes to 0 and wrap = 1.
  - reverse = 1: out_data ← out_data − 1. At 0 it goes to MAX_VALUE and wrap = 1.
- clear = 1: out_data ← 0 on the next edge. The FSM and key_state are unaffected.
- clear coinciding with an event: clear wins. out_data ← 0, wrap = 0, press_pulse still 1.
- Reset asserted mid-operation (any state): immediate return to the reset values below. A press still held when reset is released counts once, after a full debounce.

## Timing
- Reset values: out_data = 0, press_pulse = 0, wrap = 0, key_state = 0, FSM = IDLE, cnt = 0, synchronizer = 1.
- Latency: key_n held low from rising edge k (first edge that samples it low) → press_pulse and updated out_data at edge k + 1 + DEBOUNCE_CYCLES.
- press_pulse and wrap are high for exactly one cycle, registered, and aligned with the out_data change.
- key_state falls DEBOUNCE_CYCLES + 1 edges after key_n is first sampled high, if it stays stable.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- KEY_EVENT_AUTOREPEAT_EN defined:
  - In PRESSED, a repeat counter counts cycles. Every REPEAT_CYCLES cycles of continuous PRESSED it emits an additional event, with the same count, wrap and clear rules.
  - The repeat counter is zeroed on entry to PRESSED from PRESS_WAIT. It holds its value while in RELEASE_WAIT and resumes on bounce-back to PRESSED.
- Not defined: no repeat counter is built; exactly one event per accepted press. REPEAT_CYCLES is ignored.

## Test plan
Unless noted, parameters are DEBOUNCE_CYCLES = 4, MAX_VALUE = 9, WIDTH = 8.
- Reset check: assert rst_n_a with key_n = 0 → all outputs 0. After release, holding key_n = 0 gives out_data = 1 at edge 6 after release; no event before that.
- Clean press (key_n low from edge k, reverse = 0) → press_pulse = 1 only at edge k + 5, out_data 0 → 1, key_state = 1. Release → key_state 0 at edge k' + 5, no second event.
- Bounce rejection: key_n toggles low 3 cycles / high 1 cycle for 40 cycles → out_data stays 0, press_pulse never 1. A 1-cycle high glitch while PRESSED → no new event.
- Wrap: 9 presses up then one more → out_data 9 → 0 with wrap = 1. reverse = 1 press at 0 → out_data = 9, wrap = 1.
- Clear: out_data = 5 and clear pulsed alone → 0 next edge. Clear on an event edge with out_data = 9 → out_data = 0, wrap = 0, press_pulse = 1.
- Auto-repeat (macro defined, REPEAT_CYCLES = 8): hold key_n low 30 cycles past the first event → events at first-event edge + 8, + 16, + 24, out_data = 4. Without the macro → out_data = 1.

Source files
------------

// File: rtl/key_event_counter.sv
// key_event_counter: synchronise and debounce one active-low push-button,
// turning each accepted press into a one-cycle event that steps a wrap-around count.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronised samples needed to accept a level change (>= 2)
//   WIDTH            count width
//   MAX_VALUE        highest count value (<= 2**WIDTH-1)
//   REPEAT_CYCLES    auto-repeat period in cycles
//
// Ports:
//   clk          board clock, rising edge
//   rst_n_a      asynchronous active-low reset
//   key_n        raw, bouncy, asynchronous button (0 = pressed)
//   reverse      0 = count up, 1 = count down (sampled on the event edge)
//   clear        synchronous count clear; wins over a coincident event
//   out_data     current count
//   press_pulse  one-cycle strobe per accepted event
//   wrap         one-cycle strobe when the count wraps
//   key_state    debounced level (1 = pressed)
//
// Optional feature: define KEY_EVENT_AUTOREPEAT_EN to emit an extra event
// every REPEAT_CYCLES cycles while the button stays pressed.

module key_event_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned MAX_VALUE       = 255,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic             clk,
  input  logic             rst_n_a,
  input  logic             key_n,
  input  logic             reverse,
  input  logic             clear,
  output logic [WIDTH-1:0] out_data,
  output logic             press_pulse,
  output logic             wrap,
  output logic             key_state
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Two-flop synchroniser. Resets to "released" so that a key held
  // through reset needs a full debounce before it counts.
  // ------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_key_sync;

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key_sync = r_sync2;

  // ------------------------------------------------------------------
  // Debounce FSM: state register
  // ------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_key_state;
  logic          w_key_state_nxt;
  logic          w_accept;

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_key_state <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_state <= w_key_state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Debounce FSM: next state
  // The edge that moves into a wait state is itself the first stable
  // sample, hence the counter is loaded with 1 rather than 0.
  // ------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_key_state_nxt = r_key_state;
    w_accept        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_key_sync) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (w_key_sync) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt     = PRESSED;
          w_cnt_nxt       = '0;
          w_key_state_nxt = 1'b1;
          w_accept        = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (w_key_sync) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!w_key_sync) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt     = IDLE;
          w_cnt_nxt       = '0;
          w_key_state_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Auto-repeat
  // ------------------------------------------------------------------
  logic w_rep_evt;

`ifdef KEY_EVENT_AUTOREPEAT_EN
  localparam int unsigned RW =
    (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_ONE  = RW'(1);

  logic [RW-1:0] r_rep;
  logic          w_rep_run;

  // Only cycles spent staying in PRESSED advance the period; a bounce
  // through RELEASE_WAIT pauses it without losing progress.
  assign w_rep_run = (r_state == PRESSED) && !w_key_sync;
  assign w_rep_evt = w_rep_run && (r_rep == REP_LAST);

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      r_rep <= '0;
    end else if (w_accept) begin
      r_rep <= '0;
    end else if (w_rep_run) begin
      if (r_rep == REP_LAST) begin
        r_rep <= '0;
      end else begin
        r_rep <= r_rep + REP_ONE;
      end
    end
  end
`else
  logic w_unused_rep;

  assign w_unused_rep = ^REPEAT_CYCLES;
  assign w_rep_evt    = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Counter next value. Clear has priority over an event but the
  // event strobe is still reported.
  // ------------------------------------------------------------------
  logic             w_event;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             r_pulse;
  logic             r_wrap;

  assign w_event = w_accept | w_rep_evt;

  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    if (clear) begin
      w_count_nxt = '0;
    end else if (w_event) begin
      if (!reverse) begin
        if (r_count >= MAXV) begin
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count + ONE;
        end
      end else begin
        if (r_count == '0) begin
          w_count_nxt = MAXV;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      r_count <= '0;
      r_pulse <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_pulse <= w_event;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign out_data    = r_count;
  assign press_pulse = r_pulse;
  assign wrap        = r_wrap;
  assign key_state   = r_key_state;

endmodule
